// File: rtl/toggle_seq.sv
// toggle_seq: alternates out_vec between vec_a and vec_b, one-shot or continuous.
// Optional inter-pulse gap phase with vec_gap under `TOGGLE_SEQ_GAP_EN.
module toggle_seq #(
  parameter int VEC_W = 5,
  parameter int CNT_W = 12,
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             locked,
  input  logic             mode,
  input  logic [CNT_W-1:0] cnt_upto,
  input  logic [DLY_W-1:0] setup_cyc,
  input  logic [DLY_W-1:0] hold_cyc,
`ifdef TOGGLE_SEQ_GAP_EN
  input  logic [DLY_W-1:0] gap_cyc,
  input  logic [VEC_W-1:0] vec_gap,
`endif
  input  logic [VEC_W-1:0] vec_a,
  input  logic [VEC_W-1:0] vec_b,
  output logic [VEC_W-1:0] out_vec,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt,
`ifdef TOGGLE_SEQ_GAP_EN
  output logic [2:0]       state
`else
  output logic [1:0]       state
`endif
);

`ifdef TOGGLE_SEQ_GAP_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_PH_A   = 3'b001,
    ST_PH_B   = 3'b010,
    ST_DONE   = 3'b011,
    ST_PH_GAP = 3'b100
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PH_A = 2'b01,
    ST_PH_B = 2'b10,
    ST_DONE = 2'b11
  } state_t;
`endif

  localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_sel;
  logic             r_done;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [DLY_W-1:0] r_dly;
  logic             r_mode_l;
  logic [CNT_W-1:0] r_cnt_l;
  logic [DLY_W-1:0] r_setup_l;
  logic [DLY_W-1:0] r_hold_l;

  state_t           w_nxt_state;
  logic             w_nxt_sel;
  logic             w_nxt_done;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [DLY_W-1:0] w_nxt_dly;
  logic             w_latch;
  logic             w_nxt_busy;
  logic [DLY_W-1:0] w_setup_len;
  logic [DLY_W-1:0] w_hold_len;

`ifdef TOGGLE_SEQ_GAP_EN
  logic             r_gap;
  logic [DLY_W-1:0] r_gap_l;
  logic             w_nxt_gap;
  logic [DLY_W-1:0] w_gap_len;
  assign w_gap_len = (gap_cyc == '0) ? DLY_ONE : gap_cyc;
`endif

  // Zero-length phases are stretched to one cycle at capture time.
  assign w_setup_len = (setup_cyc == '0) ? DLY_ONE : setup_cyc;
  assign w_hold_len  = (hold_cyc == '0) ? DLY_ONE : hold_cyc;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_done  = r_done;
    w_nxt_cnt   = r_cnt;
    w_nxt_dly   = r_dly;
    w_latch     = 1'b0;
`ifdef TOGGLE_SEQ_GAP_EN
    w_nxt_gap   = r_gap;
`endif
    case (r_state)
      ST_IDLE: begin
        w_nxt_sel  = 1'b0;
        w_nxt_done = 1'b0;
        w_nxt_cnt  = '0;
        w_nxt_dly  = '0;
        if (enable && locked) begin
          w_latch = 1'b1;
          if (!mode && cnt_upto == '0) begin
            w_nxt_state = ST_DONE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = ST_PH_A;
          end
        end
      end
      ST_PH_A: begin
        if (!enable) begin
          w_nxt_state = ST_IDLE;
          w_nxt_sel   = 1'b0;
          w_nxt_done  = 1'b0;
          w_nxt_cnt   = '0;
          w_nxt_dly   = '0;
        end else if (r_dly == r_setup_l - DLY_ONE) begin
          w_nxt_state = ST_PH_B;
          w_nxt_sel   = 1'b1;
          w_nxt_cnt   = r_cnt + CNT_ONE;
          w_nxt_dly   = '0;
        end else begin
          w_nxt_dly = r_dly + DLY_ONE;
        end
      end
      ST_PH_B: begin
        if (!enable) begin
          w_nxt_state = ST_IDLE;
          w_nxt_sel   = 1'b0;
          w_nxt_done  = 1'b0;
          w_nxt_cnt   = '0;
          w_nxt_dly   = '0;
        end else if (r_dly == r_hold_l - DLY_ONE) begin
          w_nxt_sel = 1'b0;
          w_nxt_dly = '0;
          if (!r_mode_l && r_cnt == r_cnt_l) begin
            w_nxt_state = ST_DONE;
            w_nxt_done  = 1'b1;
          end else begin
`ifdef TOGGLE_SEQ_GAP_EN
            w_nxt_state = ST_PH_GAP;
            w_nxt_gap   = 1'b1;
`else
            w_nxt_state = ST_PH_A;
`endif
          end
        end else begin
          w_nxt_dly = r_dly + DLY_ONE;
        end
      end
`ifdef TOGGLE_SEQ_GAP_EN
      ST_PH_GAP: begin
        if (!enable) begin
          w_nxt_state = ST_IDLE;
          w_nxt_sel   = 1'b0;
          w_nxt_done  = 1'b0;
          w_nxt_cnt   = '0;
          w_nxt_dly   = '0;
          w_nxt_gap   = 1'b0;
        end else if (r_dly == r_gap_l - DLY_ONE) begin
          w_nxt_state = ST_PH_A;
          w_nxt_gap   = 1'b0;
          w_nxt_dly   = '0;
        end else begin
          w_nxt_dly = r_dly + DLY_ONE;
        end
      end
`endif
      ST_DONE: begin
        w_nxt_sel  = 1'b0;
        w_nxt_done = 1'b1;
        if (!enable) begin
          w_nxt_state = ST_IDLE;
          w_nxt_done  = 1'b0;
          w_nxt_cnt   = '0;
          w_nxt_dly   = '0;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_sel   = 1'b0;
        w_nxt_done  = 1'b0;
        w_nxt_cnt   = '0;
        w_nxt_dly   = '0;
`ifdef TOGGLE_SEQ_GAP_EN
        w_nxt_gap   = 1'b0;
`endif
      end
    endcase
  end

`ifdef TOGGLE_SEQ_GAP_EN
  assign w_nxt_busy = (w_nxt_state == ST_PH_A) ||
                      (w_nxt_state == ST_PH_B) ||
                      (w_nxt_state == ST_PH_GAP);
`else
  assign w_nxt_busy = (w_nxt_state == ST_PH_A) ||
                      (w_nxt_state == ST_PH_B);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_dly   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_done  <= w_nxt_done;
      r_busy  <= w_nxt_busy;
      r_cnt   <= w_nxt_cnt;
      r_dly   <= w_nxt_dly;
    end
  end

  // Run parameters are frozen on the IDLE exit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_l  <= 1'b0;
      r_cnt_l   <= '0;
      r_setup_l <= DLY_ONE;
      r_hold_l  <= DLY_ONE;
    end else if (w_latch) begin
      r_mode_l  <= mode;
      r_cnt_l   <= cnt_upto;
      r_setup_l <= w_setup_len;
      r_hold_l  <= w_hold_len;
    end
  end

`ifdef TOGGLE_SEQ_GAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap   <= 1'b0;
      r_gap_l <= DLY_ONE;
    end else begin
      r_gap <= w_nxt_gap;
      if (w_latch) begin
        r_gap_l <= w_gap_len;
      end
    end
  end

  assign out_vec = r_gap ? vec_gap : (r_sel ? vec_b : vec_a);
`else
  assign out_vec = r_sel ? vec_b : vec_a;
`endif

  assign done      = r_done;
  assign busy      = r_busy;
  assign pulse_cnt = r_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_toggle_seq.sv
// Bench for toggle_seq: directed scenarios plus random runs against a
// timeline model (cycles since start, split into A/B periods).
module tb_toggle_seq;
  localparam int VW = 5;
  localparam int CW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          locked;
  logic          mode;
  logic [CW-1:0] cnt_upto;
  logic [DW-1:0] setup_cyc;
  logic [DW-1:0] hold_cyc;
  logic [VW-1:0] vec_a;
  logic [VW-1:0] vec_b;
  logic [VW-1:0] out_vec;
  logic          done;
  logic          busy;
  logic [CW-1:0] pulse_cnt;
  logic [1:0]    state;

  int n_chk = 0;
  int n_err = 0;

  bit m_run;
  bit m_done;
  bit m_M;
  int m_t;
  int m_S;
  int m_H;
  int m_N;

  always #5 clk = ~clk;

  toggle_seq #(.VEC_W(VW), .CNT_W(CW), .DLY_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .locked    (locked),
    .mode      (mode),
    .cnt_upto  (cnt_upto),
    .setup_cyc (setup_cyc),
    .hold_cyc  (hold_cyc),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .out_vec   (out_vec),
    .done      (done),
    .busy      (busy),
    .pulse_cnt (pulse_cnt),
    .state     (state)
  );

  function automatic int lenof(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_t    = 0;
  endtask

  // Expected outputs follow from the position in the run timeline.
  task automatic check_all(input string tag);
    int       per;
    int       w;
    bit       sel;
    int       es;
    int       ep;
    logic [VW-1:0] ev;
    sel = 1'b0;
    es  = 0;
    ep  = 0;
    if (m_run) begin
      per = m_S + m_H;
      w   = m_t % per;
      sel = (w >= m_S);
      es  = sel ? 2 : 1;
      ep  = (m_t / per + (sel ? 1 : 0)) % (1 << CW);
    end else if (m_done) begin
      es = 3;
      ep = m_N;
    end
    ev = sel ? vec_b : vec_a;
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".out_vec"}, 32'(out_vec), 32'(ev));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".pulse_cnt"}, 32'(pulse_cnt), 32'(ep));
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else if (m_run) begin
      if (!enable) begin
        m_run = 1'b0;
      end else begin
        m_t++;
        if (!m_M && m_t == m_N * (m_S + m_H)) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (m_done) begin
      if (!enable) m_done = 1'b0;
    end else if (enable && locked) begin
      m_M = mode;
      m_N = int'(cnt_upto);
      m_S = lenof(int'(setup_cyc));
      m_H = lenof(int'(hold_cyc));
      m_t = 0;
      if (!m_M && m_N == 0) m_done = 1'b1;
      else m_run = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rnd_vec();
    vec_a = VW'($urandom);
    vec_b = VW'($urandom);
  endtask

  task automatic rst_pulse(input string tag);
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    #2;
    reset = 1'b0;
  endtask

  task automatic bound_fail(input string tag);
    n_chk++;
    n_err++;
    $error("FAIL %s observed=timeout expected=condition", tag);
  endtask

  function automatic bit in_ph_a();
    return m_run && ((m_t % (m_S + m_H)) < m_S);
  endfunction

  function automatic bit in_ph_b_cnt3();
    int per;
    if (!m_run) return 1'b0;
    per = m_S + m_H;
    return ((m_t % per) >= m_S) && (m_t / per + 1 == 3);
  endfunction

  initial begin
    bit found;
    reset     = 1'b1;
    enable    = 1'b0;
    locked    = 1'b0;
    mode      = 1'b0;
    cnt_upto  = '0;
    setup_cyc = '0;
    hold_cyc  = '0;
    vec_a     = 5'h01;
    vec_b     = 5'h1E;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // One-shot 3 pulses, setup 3, hold 2.
    enable = 1'b1; locked = 1'b1; mode = 1'b0;
    cnt_upto = 4'd3; setup_cyc = 4'd3; hold_cyc = 4'd2;
    repeat (18) step("oneshot");
    enable = 1'b0;
    repeat (2) step("oneshot_exit");

    // Start gated by lock.
    locked = 1'b0; enable = 1'b1;
    repeat (50) step("nolock");
    locked = 1'b1;
    step("lock_start");
    locked = 1'b0;
    repeat (3) step("lock_drop");
    enable = 1'b0;
    step("abort_a");
    locked = 1'b1;

    // Zero-pulse one-shot.
    cnt_upto = '0; mode = 1'b0; enable = 1'b1;
    repeat (3) step("zero");
    enable = 1'b0;
    repeat (2) step("zero_exit");

    // Continuous mode wraps the pulse counter.
    mode = 1'b1; setup_cyc = 4'd1; hold_cyc = 4'd1; enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd_vec();
      step("cont");
    end
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (in_ph_a()) found = 1'b1;
      else step("cont_seek");
    end
    if (!found) bound_fail("cont_seek");
    enable = 1'b0;
    step("cont_abort");
    step("cont_idle");

    // Zero lengths, parameter changes mid-run ignored.
    mode = 1'b0; setup_cyc = '0; hold_cyc = '0; cnt_upto = 4'd5;
    enable = 1'b1;
    repeat (3) step("zlen");
    cnt_upto = 4'd2; setup_cyc = 4'd7; mode = 1'b1;
    repeat (12) step("zlen_hold");
    enable = 1'b0;
    step("zlen_exit");

    // Async reset in phase B with three pulses counted.
    mode = 1'b0; cnt_upto = 4'd5; setup_cyc = 4'd2; hold_cyc = 4'd3;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("pre_rst");
      if (in_ph_b_cnt3()) found = 1'b1;
    end
    if (!found) bound_fail("pre_rst");
    rst_pulse("mid_rst");
    enable = 1'b0;
    repeat (2) step("post_rst");

    // Randomized runs.
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 24) != 0);
      locked    = ($urandom_range(0, 9) != 0);
      mode      = ($urandom_range(0, 3) == 0);
      cnt_upto  = CW'($urandom_range(0, 4));
      setup_cyc = DW'($urandom_range(0, 4));
      hold_cyc  = DW'($urandom_range(0, 4));
      rnd_vec();
      if ($urandom_range(0, 199) == 0) rst_pulse("rand_rst");
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
